// File: rtl/risc_pkg.sv
// Shared RISC-Net definitions: opcodes, instruction field positions, the
// per-opcode register-usage decode and the decode packet layout.
package risc_pkg;

    localparam int REG_COUNT_DEFAULT = 16;
    localparam int REG_ID_W          = 4;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 22;
    localparam int RS1_HI = 21;
    localparam int RS1_LO = 18;
    localparam int RS2_HI = 17;
    localparam int RS2_LO = 14;
    localparam int IMM_HI = 13;
    localparam int IMM_LO = 0;

    typedef enum logic [5:0] {
        OP_NOP  = 6'h00,
        OP_ADD  = 6'h01,
        OP_SUB  = 6'h02,
        OP_AND  = 6'h03,
        OP_OR   = 6'h04,
        OP_ADDI = 6'h08,
        OP_LD   = 6'h10,
        OP_ST   = 6'h11,
        OP_BEQ  = 6'h18,
        OP_HALT = 6'h3F
    } opcode_e;

    typedef struct packed {
        logic legal;
        logic wr_rd;
        logic rd_rs1;
        logic rd_rs2;
    } op_class_t;

    typedef struct packed {
        logic [5:0]          op;
        logic [REG_ID_W-1:0] rd;
        logic [31:0]         pc;
        logic [31:0]         a;
        logic [31:0]         b;
        logic [31:0]         imm;
        logic                illegal;
        logic                sets_busy;
    } dec_pkt_t;

    // Undefined opcodes fall to all-zero: no reads, no write, not legal.
    function automatic op_class_t classify_op(input logic [5:0] op);
        op_class_t c;
        c = '0;
        case (op)
            OP_NOP, OP_HALT: c.legal = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                c.legal = 1'b1; c.wr_rd = 1'b1; c.rd_rs1 = 1'b1; c.rd_rs2 = 1'b1;
            end
            OP_ADDI, OP_LD: begin
                c.legal = 1'b1; c.wr_rd = 1'b1; c.rd_rs1 = 1'b1;
            end
            OP_ST, OP_BEQ: begin
                c.legal = 1'b1; c.rd_rs1 = 1'b1; c.rd_rs2 = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] sext_imm(input logic [IMM_HI-IMM_LO:0] imm);
        return {{(31-IMM_HI){imm[IMM_HI-IMM_LO]}}, imm};
    endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
// slave = decode stage view, master = surrounding pipeline view.
interface instruction_decode_if;
    import risc_pkg::*;

    logic                if_valid;
    logic                if_ready;
    logic [31:0]         if_instr;
    logic [31:0]         if_pc;
    logic                id_valid;
    logic                id_ready;
    logic [5:0]          id_op;
    logic [REG_ID_W-1:0] id_rd;
    logic [31:0]         id_pc;
    logic [31:0]         id_a;
    logic [31:0]         id_b;
    logic [31:0]         id_imm;
    logic                id_illegal;

    modport master (
        output if_valid, if_instr, if_pc, id_ready,
        input  if_ready, id_valid, id_op, id_rd, id_pc, id_a, id_b, id_imm, id_illegal
    );

    modport slave (
        input  if_valid, if_instr, if_pc, id_ready,
        output if_ready, id_valid, id_op, id_rd, id_pc, id_a, id_b, id_imm, id_illegal
    );

endinterface

// File: rtl/instruction_decode_scoreboard.sv
// In-flight destination tracker: one busy bit per register, r0 never busy.
module reg_scoreboard
    import risc_pkg::*;
#(
    parameter int REG_COUNT = REG_COUNT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [REG_ID_W-1:0] set_addr,
    input  logic                clr_en,
    input  logic [REG_ID_W-1:0] clr_addr,
    input  logic                kill_en,
    input  logic [REG_ID_W-1:0] kill_addr,
    input  logic [REG_ID_W-1:0] q1_addr,
    input  logic [REG_ID_W-1:0] q2_addr,
    output logic                q1_busy,
    output logic                q2_busy
);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;

    // Set is applied last so a same-cycle retire of an older writer loses.
    always_comb begin
        busy_d = busy_q;
        if (clr_en)  busy_d[clr_addr]  = 1'b0;
        if (kill_en) busy_d[kill_addr] = 1'b0;
        if (set_en)  busy_d[set_addr]  = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign q1_busy = busy_q[q1_addr];
    assign q2_busy = busy_q[q2_addr];

endmodule

// File: rtl/instruction_decode.sv
// RISC-Net decode stage: field split, operand read, RAW stall, output register.
// Define ID_BYPASS_EN to forward the writeback value into a same-cycle accept.
module instruction_decode
    import risc_pkg::*;
#(
    parameter int REG_COUNT = REG_COUNT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_decode_if.slave bus,
    output logic [REG_ID_W-1:0] rf_raddr1,
    output logic [REG_ID_W-1:0] rf_raddr2,
    input  logic [31:0]         rf_rdata1,
    input  logic [31:0]         rf_rdata2,
    input  logic                wb_en,
    input  logic [REG_ID_W-1:0] wb_addr,
    input  logic [31:0]         wb_data,
    input  logic                flush
);

    logic [5:0]          op;
    logic [REG_ID_W-1:0] rd, rs1, rs2;
    op_class_t           cls;
    logic                busy1, busy2, byp1, byp2;
    logic                hazard, if_ready_w, accept, sets_busy;
    logic [31:0]         a_val, b_val;
    logic                id_valid_q, id_valid_d;
    dec_pkt_t            pkt_q, pkt_d;

    assign op  = bus.if_instr[OP_HI:OP_LO];
    assign rd  = bus.if_instr[RD_HI:RD_LO];
    assign rs1 = bus.if_instr[RS1_HI:RS1_LO];
    assign rs2 = bus.if_instr[RS2_HI:RS2_LO];
    assign cls = classify_op(op);

    assign rf_raddr1 = rs1;
    assign rf_raddr2 = rs2;

`ifdef ID_BYPASS_EN
    assign byp1 = wb_en && (wb_addr == rs1) && (rs1 != '0);
    assign byp2 = wb_en && (wb_addr == rs2) && (rs2 != '0);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign hazard     = bus.if_valid && ((cls.rd_rs1 && busy1 && !byp1) ||
                                         (cls.rd_rs2 && busy2 && !byp2));
    assign if_ready_w = !hazard && !flush && (!id_valid_q || bus.id_ready);
    assign accept     = bus.if_valid && if_ready_w;
    assign sets_busy  = cls.wr_rd && (rd != '0);

    // Unread operands and r0 are presented as zero.
    assign a_val = (cls.rd_rs1 && rs1 != '0) ? (byp1 ? wb_data : rf_rdata1) : '0;
    assign b_val = (cls.rd_rs2 && rs2 != '0) ? (byp2 ? wb_data : rf_rdata2) : '0;

    reg_scoreboard #(.REG_COUNT(REG_COUNT)) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (accept && sets_busy),
        .set_addr (rd),
        .clr_en   (wb_en),
        .clr_addr (wb_addr),
        .kill_en  (flush && id_valid_q && pkt_q.sets_busy),
        .kill_addr(pkt_q.rd),
        .q1_addr  (rs1),
        .q2_addr  (rs2),
        .q1_busy  (busy1),
        .q2_busy  (busy2)
    );

    always_comb begin
        id_valid_d = id_valid_q;
        pkt_d      = pkt_q;
        if (accept) begin
            id_valid_d = 1'b1;
            pkt_d      = '{op: op, rd: rd, pc: bus.if_pc, a: a_val, b: b_val,
                           imm: sext_imm(bus.if_instr[IMM_HI:IMM_LO]),
                           illegal: !cls.legal, sets_busy: sets_busy};
        end else if (flush || bus.id_ready) begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q <= 1'b0;
            pkt_q      <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            pkt_q      <= pkt_d;
        end
    end

    assign bus.if_ready   = if_ready_w;
    assign bus.id_valid   = id_valid_q;
    assign bus.id_op      = pkt_q.op;
    assign bus.id_rd      = pkt_q.rd;
    assign bus.id_pc      = pkt_q.pc;
    assign bus.id_a       = pkt_q.a;
    assign bus.id_b       = pkt_q.b;
    assign bus.id_imm     = pkt_q.imm;
    assign bus.id_illegal = pkt_q.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode table plus stall, backpressure,
// flush and reset sequences. Expected values are hand-computed constants.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic [31:0] rf_mem [16];

    int n_chk  = 0;
    int n_fail = 0;

    instruction_decode_if bus ();

    instruction_decode dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rf_raddr1(rf_raddr1),
        .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .flush    (flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rf_init(input int i);
        case (i)
            0:       return 32'd0;
            2:       return 32'd5;
            3:       return 32'd7;
            default: return 32'h1000 + i;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) for (int i = 0; i < 16; i++) rf_mem[i] <= rf_init(i);
        else if (wb_en && wb_addr != 4'd0) rf_mem[wb_addr] <= wb_data;
    end
    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [13:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [3:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        ill;
        logic        wr;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
        bus.if_pc    = pc;
    endtask

    task automatic retire(input logic [3:0] r, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = r; wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{enc(6'h01, 4'd1, 4'd2, 4'd3, 14'h0000), 32'h100, 6'h01, 4'd1, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1};
        vecs[1]  = '{enc(6'h02, 4'd4, 4'd2, 4'd3, 14'h0005), 32'h104, 6'h02, 4'd4, 32'd5, 32'd7, 32'h5, 1'b0, 1'b1};
        vecs[2]  = '{enc(6'h08, 4'd5, 4'd0, 4'd3, 14'h3FFF), 32'h108, 6'h08, 4'd5, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1};
        vecs[3]  = '{enc(6'h10, 4'd6, 4'd2, 4'd0, 14'h2000), 32'h10C, 6'h10, 4'd6, 32'd5, 32'd0, 32'hFFFFE000, 1'b0, 1'b1};
        vecs[4]  = '{enc(6'h11, 4'd7, 4'd3, 4'd2, 14'h0010), 32'h110, 6'h11, 4'd7, 32'd7, 32'd5, 32'h10, 1'b0, 1'b0};
        vecs[5]  = '{enc(6'h2A, 4'd9, 4'd2, 4'd3, 14'h0001), 32'h114, 6'h2A, 4'd9, 32'd0, 32'd0, 32'h1, 1'b1, 1'b0};
        vecs[6]  = '{enc(6'h18, 4'd0, 4'd9, 4'd8, 14'h1FFF), 32'h118, 6'h18, 4'd0, 32'h1009, 32'h1008, 32'h1FFF, 1'b0, 1'b0};
        vecs[7]  = '{enc(6'h00, 4'd0, 4'd2, 4'd3, 14'h0000), 32'h11C, 6'h00, 4'd0, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0};
        vecs[8]  = '{enc(6'h3F, 4'd0, 4'd0, 4'd0, 14'h0000), 32'h120, 6'h3F, 4'd0, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0};
        vecs[9]  = '{enc(6'h03, 4'd10, 4'd11, 4'd12, 14'h0000), 32'h124, 6'h03, 4'd10, 32'h100B, 32'h100C, 32'h0, 1'b0, 1'b1};
        vecs[10] = '{enc(6'h04, 4'd15, 4'd14, 4'd13, 14'h2000), 32'h128, 6'h04, 4'd15, 32'h100E, 32'h100D, 32'hFFFFE000, 1'b0, 1'b1};

        rst_n = 1'b0; wb_en = 1'b0; wb_addr = 4'd0; wb_data = 32'd0; flush = 1'b0;
        bus.if_valid = 1'b0; bus.if_instr = 32'd0; bus.if_pc = 32'd0; bus.id_ready = 1'b1;
        step(); step();
        chk("reset_id_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("reset_id_op", {26'd0, bus.id_op}, 32'd0);
        chk("reset_id_a", bus.id_a, 32'd0);
        chk("reset_id_imm", bus.id_imm, 32'd0);
        chk("reset_id_pc", bus.id_pc, 32'd0);
        chk("reset_id_illegal", {31'd0, bus.id_illegal}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_if_ready", {31'd0, bus.if_ready}, 32'd1);
        step();

        // Decode table: accept, inspect packet, then retire the destination.
        for (int i = 0; i < 11; i++) begin
            present(vecs[i].instr, vecs[i].pc);
            @(negedge clk);
            chk($sformatf("v%0d_if_ready", i), {31'd0, bus.if_ready}, 32'd1);
            step();
            bus.if_valid = 1'b0;
            chk($sformatf("v%0d_id_valid", i), {31'd0, bus.id_valid}, 32'd1);
            chk($sformatf("v%0d_op", i), {26'd0, bus.id_op}, {26'd0, vecs[i].op});
            chk($sformatf("v%0d_rd", i), {28'd0, bus.id_rd}, {28'd0, vecs[i].rd});
            chk($sformatf("v%0d_pc", i), bus.id_pc, vecs[i].pc);
            chk($sformatf("v%0d_a", i), bus.id_a, vecs[i].a);
            chk($sformatf("v%0d_b", i), bus.id_b, vecs[i].b);
            chk($sformatf("v%0d_imm", i), bus.id_imm, vecs[i].imm);
            chk($sformatf("v%0d_illegal", i), {31'd0, bus.id_illegal}, {31'd0, vecs[i].ill});
            if (vecs[i].wr) retire(vecs[i].rd, rf_init(int'(vecs[i].rd)));
            else step();
            chk($sformatf("v%0d_drain", i), {31'd0, bus.id_valid}, 32'd0);
        end

        // RAW: ADD r1 then SUB r4,r1,r2 stalls until r1 retires.
        present(enc(6'h01, 4'd1, 4'd2, 4'd3, 14'd0), 32'h200);
        step();
        present(enc(6'h02, 4'd4, 4'd1, 4'd2, 14'd0), 32'h204);
        @(negedge clk);
        chk("raw_stall0", {31'd0, bus.if_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("raw_stall1", {31'd0, bus.if_ready}, 32'd0);
        step();
        wb_en = 1'b1; wb_addr = 4'd1; wb_data = 32'hDEAD;
        @(negedge clk);
`ifdef ID_BYPASS_EN
        chk("raw_wb_cycle_ready", {31'd0, bus.if_ready}, 32'd1);
        step();
        wb_en = 1'b0;
`else
        chk("raw_wb_cycle_ready", {31'd0, bus.if_ready}, 32'd0);
        step();
        wb_en = 1'b0;
        @(negedge clk);
        chk("raw_after_wb_ready", {31'd0, bus.if_ready}, 32'd1);
        step();
`endif
        bus.if_valid = 1'b0;
        chk("raw_sub_valid", {31'd0, bus.id_valid}, 32'd1);
        chk("raw_sub_op", {26'd0, bus.id_op}, 32'h02);
        chk("raw_sub_a", bus.id_a, 32'hDEAD);
        chk("raw_sub_b", bus.id_b, 32'd5);
        retire(4'd4, 32'h1004);

        // Backpressure: packet held while id_ready is low.
        bus.id_ready = 1'b0;
        present(enc(6'h01, 4'd10, 4'd2, 4'd3, 14'd0), 32'h300);
        step();
        present(enc(6'h04, 4'd11, 4'd3, 4'd2, 14'd0), 32'h304);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_if_ready", c), {31'd0, bus.if_ready}, 32'd0);
            chk($sformatf("bp%0d_valid", c), {31'd0, bus.id_valid}, 32'd1);
            chk($sformatf("bp%0d_op", c), {26'd0, bus.id_op}, 32'h01);
            chk($sformatf("bp%0d_pc", c), bus.id_pc, 32'h300);
            chk($sformatf("bp%0d_a", c), bus.id_a, 32'd5);
            step();
        end
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume_ready", {31'd0, bus.if_ready}, 32'd1);
        step();
        bus.if_valid = 1'b0;
        chk("bp_next_op", {26'd0, bus.id_op}, 32'h04);
        chk("bp_next_a", bus.id_a, 32'd7);
        retire(4'd10, 32'h100A);
        retire(4'd11, 32'h100B);

        // Flush kills held LD r6 and its busy bit; reader of r6 then flows.
        bus.id_ready = 1'b0;
        present(enc(6'h10, 4'd6, 4'd2, 4'd0, 14'd4), 32'h400);
        step();
        present(enc(6'h01, 4'd7, 4'd6, 4'd2, 14'd0), 32'h404);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_if_ready", {31'd0, bus.if_ready}, 32'd0);
        step();
        flush = 1'b0;
        bus.id_ready = 1'b1;
        chk("flush_id_valid", {31'd0, bus.id_valid}, 32'd0);
        @(negedge clk);
        chk("flush_reader_ready", {31'd0, bus.if_ready}, 32'd1);
        step();
        bus.if_valid = 1'b0;
        chk("flush_reader_valid", {31'd0, bus.id_valid}, 32'd1);
        chk("flush_reader_pc", bus.id_pc, 32'h404);
        chk("flush_reader_a", bus.id_a, 32'h1006);
        retire(4'd7, 32'h1007);

        // Reset asserted during a RAW stall.
        bus.id_ready = 1'b0;
        present(enc(6'h01, 4'd1, 4'd2, 4'd3, 14'd0), 32'h500);
        step();
        present(enc(6'h02, 4'd4, 4'd1, 4'd2, 14'd0), 32'h504);
        @(negedge clk);
        chk("rst_stall_ready", {31'd0, bus.if_ready}, 32'd0);
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("rst_mid_op", {26'd0, bus.id_op}, 32'd0);
        step();
        rst_n = 1'b1;
        bus.id_ready = 1'b1;
        @(negedge clk);
        chk("rst_after_ready", {31'd0, bus.if_ready}, 32'd1);
        step();
        bus.if_valid = 1'b0;
        chk("rst_after_op", {26'd0, bus.id_op}, 32'h02);
        chk("rst_after_a", bus.id_a, 32'h1001);
        chk("rst_after_b", bus.id_b, 32'd5);
        retire(4'd4, 32'h1004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
# instruction_decode

Decode stage of the RISC-Net pipeline, directly downstream of instruction fetch. Accepts one fetched instruction per cycle over a valid/ready handshake and splits it into opcode, register and immediate fields. Reads both source operands from the register file and tracks in-flight destination registers in a 16-entry scoreboard to stall on read-after-write hazards. Issues a registered decode packet to execute.

## Interface
- `REG_COUNT`, default 16: architectural registers; 4-bit register ids; r0 reads zero and is never busy.
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_valid`  in  1  fetch holds a valid instruction.
- `if_ready`  out  1  decode accepts this cycle.
- `if_instr`  in  32  instruction word.
- `if_pc`  in  32  address of `if_instr`.
- `rf_raddr1`, `rf_raddr2`  out  4  combinational register-file read addresses (rs1, rs2).
- `rf_rdata1`, `rf_rdata2`  in  32  same-cycle read data.
- `wb_en`  in  1  writeback retires a register this cycle.
- `wb_addr`  in  4  retired register id.
- `wb_data`  in  32  retired value.
- `flush`  in  1  kill the packet held in the decode output register.
- `id_valid`  out  1  decode packet valid.
- `id_ready`  in  1  execute accepts the packet.
- `id_op`  out  6  opcode.
- `id_rd`  out  4  destination register.
- `id_pc`  out  32  pc of the packet.
- `id_a`, `id_b`  out  32  operand values.
- `id_imm`  out  32  sign-extended immediate.
- `id_illegal`  out  1  opcode not in the defined set.

## Operation
- Fields: op=[31:26], rd=[25:22], rs1=[21:18], rs2=[17:14], imm=[13:0], sign-extended to 32 bits.
- Defined opcodes: NOP 0x00, ADD 0x01, SUB 0x02, AND 0x03, OR 0x04, ADDI 0x08, LD 0x10, ST 0x11, BEQ 0x18, HALT 0x3F.
- Writes rd: ADD, SUB, AND, OR, ADDI, LD. Reads rs2: ADD, SUB, AND, OR, ST, BEQ. Reads rs1: all except NOP and HALT.
- Illegal opcode: `id_illegal`=1; the packet is treated as a non-writing, non-reading instruction.
- Scoreboard: one busy bit per register.
  - Set on input accept when the instruction writes a register with rd≠0.
  - Cleared on `wb_en` for `wb_addr`.
  - Set and clear to the same register in the same cycle: set wins.
- Hazard: a read source is busy. While a hazard exists, `if_ready`=0 and the instruction stays at the input.
- `if_ready` = !hazard && !flush && (!id_valid || id_ready).
- Output register loads on accept. On a cycle with no accept, `id_valid` clears if `id_ready`=1; otherwise the packet holds unchanged.
- Flush: `id_valid` clears next edge. If the killed packet set a busy bit, that bit clears on the same edge. No accept occurs in a flush cycle. Packets already taken by execute are unaffected.

## Timing
- Latency 1: instruction accepted at edge N is presented on `id_*` after edge N.
- Throughput: 1 instruction/cycle when there is no hazard and no backpressure.
- Without bypass, a source retired by `wb_en` in cycle N is readable by accept at edge N+1.
- Reset values: `id_valid`=0, every `id_*` data output 0, `id_illegal`=0, all busy bits 0. `if_ready` follows its equation, so it is 1 after reset.
- Reset asserted mid-stall discards the held packet and clears the scoreboard.

## Configuration
- `ID_BYPASS_EN` defined:
  - A busy source whose id equals `wb_addr` while `wb_en`=1 is not a hazard.
  - That operand takes `wb_data` instead of the register-file value, so the accept happens in the retire cycle.
- `ID_BYPASS_EN` undefined: no forwarding; stall until the cycle after retire.

## Structure
- Shared package `risc_pkg`: opcode constants, field bit positions, the writes-rd / reads-rs1 / reads-rs2 decode function, and the `REG_COUNT` default.
- One sub-module, `reg_scoreboard`:
  - set port, clear port, kill-clear port.
  - Two query ports returning busy for rs1 and rs2.

## Test plan
- Reset, then ADD r1,r2,r3 with rf r2=5, r3=7 → one cycle later `id_valid`=1, op=0x01, rd=1, `id_a`=5, `id_b`=7; r1 busy.
- ADD r1,r2,r3 followed by SUB r4,r1,r2:
  - Bypass off: SUB stalls until the cycle after `wb_en`/`wb_addr`=1.
  - Bypass on: SUB is accepted in the `wb_en` cycle with `id_a`=`wb_data`.
- `id_ready`=0 for 3 cycles with a valid packet → `id_*` are stable, `if_ready`=0; accept resumes the edge after `id_ready` returns to 1.
- ADDI r5,r0,imm=0x3FFF → `id_imm`=0xFFFFFFFF, `id_a`=0; opcode 0x2A → `id_illegal`=1 and no busy bit is set.
- LD r6 held in the output register, then `flush` → `id_valid`=0 next cycle and r6 is not busy; a following reader of r6 is accepted without a stall.
- `rst_n` low during a hazard stall → `id_valid`=0 and the scoreboard is clear.
